// File: rtl/mmio_timer.sv
// Memory-mapped down-counter timer with a power-of-two prescaler, one-shot/periodic
// modes, a sticky expiry flag and a level interrupt.
module mmio_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             write,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [7:0]       ctrl_q,    ctrl_d;
  logic [WIDTH-1:0] reload_q,  reload_d;
  logic [WIDTH-1:0] count_q,   count_d;
  logic [15:0]      pcnt_q,    pcnt_d;
  logic             running_q, running_d;
  logic             flag_q,    flag_d;

  logic        ctrl_en;
  logic        ctrl_periodic;
  logic [3:0]  ctrl_psc;
  logic [15:0] psc_mask;
  logic        tick;
  logic        expire;

  assign ctrl_en       = ctrl_q[0];
  assign ctrl_periodic = ctrl_q[1];
  assign ctrl_psc      = ctrl_q[7:4];

  // Only the low PSC bits of the prescaler are compared, so a tick lands every 2^PSC clocks.
  assign psc_mask = (16'd1 << ctrl_psc) - 16'd1;
  assign tick     = running_q && ((pcnt_q & psc_mask) == psc_mask);
  assign expire   = tick && (count_q == '0);

  always_comb begin
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    count_d   = count_q;
    pcnt_d    = pcnt_q;
    running_d = running_q;
    flag_d    = flag_q;

    if (running_q) begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    end else begin
      pcnt_d = 16'd0;
    end

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else if (ctrl_periodic) begin
        count_d = reload_q;
      end else begin
        running_d = 1'b0;
      end
    end

    // Clear first so that an expiry in the same cycle wins.
    if (write && (addr == ADDR_STATUS) && wdata[0]) begin
      flag_d = 1'b0;
    end
    if (expire) begin
      flag_d = 1'b1;
    end

    // Bus writes override tick-driven updates to the same register.
    if (write) begin
      case (addr)
        ADDR_CTRL: begin
          ctrl_d = {wdata[7:4], 1'b0, wdata[2:0]};
          pcnt_d = 16'd0;
          if (wdata[0] && !ctrl_en) begin
            count_d   = reload_q;
            running_d = 1'b1;
          end else if (!wdata[0]) begin
            count_d   = count_q;
            running_d = 1'b0;
          end
        end
        ADDR_RELOAD: reload_d = wdata;
        ADDR_COUNT:  count_d  = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      pcnt_q    <= '0;
      running_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      pcnt_q    <= pcnt_d;
      running_q <= running_d;
      flag_q    <= flag_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata = {{(WIDTH-8){1'b0}}, ctrl_q};
      ADDR_RELOAD: rdata = reload_q;
      ADDR_COUNT:  rdata = count_q;
      ADDR_STATUS: rdata = {{(WIDTH-2){1'b0}}, running_q, flag_q};
      default:     rdata = '0;
    endcase
  end

  assign irq = flag_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: register access, one-shot/periodic timing,
// clear/set collision, COUNT override, disable/re-enable and async reset.
module tb_mmio_timer;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic        write;
  logic [15:0] rdata;
  logic        irq;

  int checks;
  int errors;

  mmio_timer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .write (write),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Drive a write that is sampled at the next rising edge; returns 1ns after it.
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    wdata = 16'h0000;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [15:0] v;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    addr   = 2'd0;
    wdata  = 16'h0000;
    write  = 1'b0;

    // Reset state
    #2;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check($sformatf("reset_reg%0d", a), v, 16'h0000);
    end
    check("reset_irq", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // Asynchronous reset mid-run
    wr(2'd1, 16'd5);
    wr(2'd0, 16'h0005);
    step(2);
    rd(2'd2, v);
    check("prerst_count", v, 16'd3);
    rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check($sformatf("midrst_reg%0d", a), v, 16'h0000);
    end
    check("midrst_irq", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    step(5);
    rd(2'd2, v);
    check("postrst_count", v, 16'h0000);
    rd(2'd3, v);
    check("postrst_status", v, 16'h0000);

    // One-shot, PSC=0, RELOAD=3
    wr(2'd1, 16'd3);
    wr(2'd0, 16'h0005);
    for (int k = 0; k < 4; k++) begin
      rd(2'd2, v);
      check($sformatf("oneshot_count_E%0d", k), v, 16'(3 - k));
      rd(2'd3, v);
      check($sformatf("oneshot_status_E%0d", k), v, 16'b10);
      step(1);
    end
    rd(2'd3, v);
    check("oneshot_status_E4", v, 16'b01);
    check("oneshot_irq_E4", {15'd0, irq}, 16'h0001);
    step(5);
    rd(2'd2, v);
    check("oneshot_count_hold", v, 16'h0000);
    rd(2'd3, v);
    check("oneshot_status_hold", v, 16'b01);
    rd(2'd0, v);
    check("oneshot_ctrl", v, 16'h0005);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);
    rd(2'd3, v);
    check("oneshot_cleared", v, 16'h0000);
    check("oneshot_irq_cleared", {15'd0, irq}, 16'h0000);

    // Periodic, PSC=2, RELOAD=1: flag at E8, clear at E9, flag again at E16
    wr(2'd1, 16'd1);
    wr(2'd0, 16'h0023);
    step(7);
    rd(2'd3, v);
    check("periodic_status_E7", v, 16'b10);
    step(1);
    rd(2'd3, v);
    check("periodic_status_E8", v, 16'b11);
    check("periodic_irq_E8", {15'd0, irq}, 16'h0000);
    rd(2'd2, v);
    check("periodic_count_E8", v, 16'd1);
    wr(2'd3, 16'h0001);
    rd(2'd3, v);
    check("periodic_status_E9", v, 16'b10);
    step(6);
    rd(2'd3, v);
    check("periodic_status_E15", v, 16'b10);
    step(1);
    rd(2'd3, v);
    check("periodic_status_E16", v, 16'b11);
    check("periodic_irq_E16", {15'd0, irq}, 16'h0000);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);

    // Clear vs set collision: RELOAD=0 periodic expires on every cycle
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h0003);
    wr(2'd3, 16'h0001);
    rd(2'd3, v);
    check("collide_E1", v, 16'b11);
    wr(2'd3, 16'h0001);
    rd(2'd3, v);
    check("collide_E2", v, 16'b11);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);
    rd(2'd3, v);
    check("collide_cleared", v, 16'h0000);

    // COUNT override on a tick cycle
    wr(2'd1, 16'd10);
    wr(2'd0, 16'h0001);
    step(1);
    rd(2'd2, v);
    check("override_pre", v, 16'd9);
    wr(2'd2, 16'h0002);
    rd(2'd2, v);
    check("override_count_w", v, 16'd2);
    step(1);
    rd(2'd2, v);
    check("override_count_1", v, 16'd1);
    step(1);
    rd(2'd2, v);
    check("override_count_0", v, 16'd0);
    rd(2'd3, v);
    check("override_status_pre", v, 16'b10);
    step(1);
    rd(2'd3, v);
    check("override_expire", v, 16'b01);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);

    // Disable at COUNT=4, hold, then re-enable with new RELOAD and PSC=1
    wr(2'd1, 16'd10);
    wr(2'd0, 16'h0001);
    step(6);
    rd(2'd2, v);
    check("disable_pre", v, 16'd4);
    wr(2'd0, 16'h0000);
    rd(2'd2, v);
    check("disable_count", v, 16'd4);
    step(20);
    rd(2'd2, v);
    check("disable_hold", v, 16'd4);
    rd(2'd3, v);
    check("disable_status", v, 16'h0000);
    wr(2'd1, 16'd7);
    rd(2'd1, v);
    check("reload_readback", v, 16'd7);
    wr(2'd0, 16'h0011);
    rd(2'd2, v);
    check("reenable_count", v, 16'd7);
    rd(2'd0, v);
    check("reenable_ctrl", v, 16'h0011);
    step(1);
    rd(2'd2, v);
    check("reenable_pcnt1", v, 16'd7);
    step(1);
    rd(2'd2, v);
    check("reenable_tick", v, 16'd6);

    // Reserved CTRL bits read as 0
    wr(2'd0, 16'h0000);
    wr(2'd0, 16'hFFF8);
    rd(2'd0, v);
    check("ctrl_reserved", v, 16'h00F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
